// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state codes and grant owner.
package mem_arb_pkg;
  typedef logic [1:0] arb_state_t;
  localparam arb_state_t IDLE   = 2'd0;
  localparam arb_state_t BUSY_I = 2'd1;
  localparam arb_state_t BUSY_D = 2'd2;
  localparam arb_state_t RESP   = 2'd3;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_I    = 2'd1,
    GNT_D    = 2'd2
  } gnt_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, load/store port and unified memory port of the arbiter in one bundle.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;
  logic              err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    output if_rdata, if_valid, d_rdata, d_valid, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  // Core + memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ready, mem_rdata,
    input  if_rdata, if_valid, d_rdata, d_valid, err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );
endinterface

// File: rtl/mem_arb_watchdog.sv
// Saturating cycle counter with load and clear; flags the last allowed cycle of a transaction.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  input  logic          en,
  output logic          expired
);
  logic [CW-1:0] cnt;

  // cnt holds completed busy cycles, so the TIMEOUT-th busy cycle sees cnt == TIMEOUT-1
  assign expired = (cnt >= CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst || clr)         cnt <= '0;
    else if (ld)             cnt <= ld_val;
    else if (en && !expired) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and load/store; data first, fetch
// forced through after MAX_D_STREAK data grants, watchdog aborts stuck accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 255
) (
  input logic         clk,
  input logic         rst,
  mem_arbiter_if.slave bus
);
  localparam int BE_W = DATA_W / 8;
  localparam int SW   = $clog2(MAX_D_STREAK + 1);

  arb_state_t        state;
  gnt_t              gnt;
  logic [SW-1:0]     streak;
  logic              err_q, busy, grant_d, grant_i, expired;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [DATA_W-1:0] wdata_q, if_rdata_q, d_rdata_q;
  logic [BE_W-1:0]   be_q;

  assign busy    = (state == BUSY_I) || (state == BUSY_D);
  assign grant_d = (state == IDLE) && bus.d_req &&
                   (!bus.if_req || (streak < SW'(MAX_D_STREAK)));
  assign grant_i = (state == IDLE) && !grant_d && bus.if_req;

  mem_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (state == RESP),
    .ld     (grant_d || grant_i),
    .ld_val ('0),
    .en     (busy),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      gnt        <= GNT_NONE;
      streak     <= '0;
      err_q      <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      be_q       <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state   <= BUSY_D;
            gnt     <= GNT_D;
            addr_q  <= bus.d_addr;
            we_q    <= bus.d_we;
            wdata_q <= bus.d_wdata;
            be_q    <= bus.d_we ? bus.d_be : '1;
            if (streak < SW'(MAX_D_STREAK)) streak <= streak + 1'b1;
          end else if (grant_i) begin
            state   <= BUSY_I;
            gnt     <= GNT_I;
            addr_q  <= bus.if_addr;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '1;
            streak  <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          // a ready on the last allowed cycle still counts as a normal completion
          if (bus.mem_ready || expired) begin
            state <= RESP;
            err_q <= !bus.mem_ready;
            if (gnt == GNT_I) begin
              if_rdata_q <= bus.mem_ready ? bus.mem_rdata : '0;
            end else begin
              d_rdata_q  <= bus.mem_ready ? bus.mem_rdata : '0;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = busy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_be    = be_q;
  assign bus.if_valid  = (state == RESP) && (gnt == GNT_I);
  assign bus.d_valid   = (state == RESP) && (gnt == GNT_D);
  assign bus.err       = (state == RESP) && err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner cases, and a random run
// checked against a transaction-level model of arbitration and memory contents.
module tb_mem_arbiter;
  localparam int AW = 32, DW = 32, MAXS = 4, TMO = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS), .TIMEOUT(TMO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #3;
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
    bit [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // ---------------- memory responder and grant log ----------------
  bit [31:0] mem [bit [31:0]];
  int  wait_cfg = 0;
  bit  hang = 1'b0, rnd_wait = 1'b0, addr_moved = 1'b0;
  int  busy_cyc = 0, last_req_cyc = 0;
  logic [31:0] txn_addr;
  typedef struct { bit pi; bit pd; bit we; logic [31:0] addr; logic [3:0] be; } grant_t;
  grant_t gq[$];

  always begin
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    if (bus.mem_req === 1'b1) begin
      if (busy_cyc == 0) begin
        gq.push_back('{bus.if_req, bus.d_req, bus.mem_we, bus.mem_addr, bus.mem_be});
        txn_addr   = bus.mem_addr;
        addr_moved = 1'b0;
        if (rnd_wait) wait_cfg = $urandom_range(0, 3);
      end else if (bus.mem_addr !== txn_addr) addr_moved = 1'b1;
      busy_cyc++;
      if (!hang && busy_cyc > wait_cfg) begin
        bus.mem_ready = 1'b1;
        if (bus.mem_we)
          mem[bus.mem_addr] = merge(mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0,
                                    bus.mem_wdata, bus.mem_be);
        else
          bus.mem_rdata = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
      end
    end else begin
      if (busy_cyc != 0) last_req_cyc = busy_cyc;
      busy_cyc = 0;
    end
  end

  // ---------------- single-transaction driver ----------------
  typedef enum {K_I, K_LD, K_ST} kind_t;
  task automatic xact(input kind_t k, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, output logic [31:0] rdata, output logic e,
                      output int lat, output logic ok);
    if (k == K_I) begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end else begin
      bus.d_req = 1'b1; bus.d_we = (k == K_ST); bus.d_addr = addr;
      bus.d_wdata = wd; bus.d_be = be;
    end
    lat = 0; ok = 1'b0;
    while (lat < 60 && ok !== 1'b1) begin
      tick(); lat++;
      ok = (k == K_I) ? bus.if_valid : bus.d_valid;
    end
    rdata = (k == K_I) ? bus.if_rdata : bus.d_rdata;
    e = bus.err;
    bus.if_req = 1'b0; bus.d_req = 1'b0;
  endtask

  typedef struct {
    kind_t k; logic [31:0] addr; logic [31:0] wd; logic [3:0] be; int wt; bit hng;
    logic [31:0] exp_rd; bit chk_rd; bit exp_err; int exp_cyc;
  } vec_t;
  vec_t vt[12];

  // ---------------- random-phase reference model ----------------
  bit [31:0] ref_mem [bit [31:0]];
  int model_streak = 0;

  task automatic on_done(input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] rd, input logic e);
    grant_t g;
    bit exp_d;
    check("rnd_grant_logged", 32'(gq.size() != 0), 32'd1);
    if (gq.size() == 0) return;
    g = gq.pop_front();
    exp_d = g.pd && (!g.pi || model_streak < MAXS);
    check("rnd_grant_owner", 32'(is_d), 32'(exp_d));
    check("rnd_grant_addr", g.addr, addr);
    check("rnd_err", 32'(e), 32'd0);
    model_streak = is_d ? ((model_streak < MAXS) ? model_streak + 1 : MAXS) : 0;
    if (we) ref_mem[addr] = merge(ref_mem.exists(addr) ? ref_mem[addr] : 32'h0, wd, be);
    else check(is_d ? "rnd_load_data" : "rnd_fetch_data", rd,
               ref_mem.exists(addr) ? ref_mem[addr] : 32'h0);
  endtask

  task automatic i_agent();
    logic [31:0] a;
    int cyc;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 32'($urandom_range(0, 63)) << 2;
      bus.if_req = 1'b1; bus.if_addr = a;
      cyc = 0;
      do begin tick(); cyc++; end while (bus.if_valid !== 1'b1 && cyc < 200);
      check("rnd_fetch_done", 32'(bus.if_valid), 32'd1);
      if (bus.if_valid !== 1'b1) begin bus.if_req = 1'b0; return; end
      on_done(1'b0, 1'b0, a, 32'h0, 4'hF, bus.if_rdata, bus.err);
      bus.if_req = 1'b0;
    end
  endtask

  task automatic d_agent();
    logic [31:0] a, wd;
    logic [3:0]  be;
    bit we;
    int cyc;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      a  = 32'($urandom_range(0, 63)) << 2;
      we = 1'($urandom_range(0, 1));
      wd = $urandom;
      be = we ? 4'($urandom_range(1, 15)) : 4'hF;
      bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = a; bus.d_wdata = wd; bus.d_be = be;
      cyc = 0;
      do begin tick(); cyc++; end while (bus.d_valid !== 1'b1 && cyc < 200);
      check("rnd_data_done", 32'(bus.d_valid), 32'd1);
      if (bus.d_valid !== 1'b1) begin bus.d_req = 1'b0; return; end
      on_done(1'b1, we, a, wd, be, bus.d_rdata, bus.err);
      bus.d_req = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic e, ok;
    int lat, cyc;
    grant_t g;
    string pat;

    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0;
    bus.d_addr = '0; bus.d_wdata = '0; bus.d_be = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0;
    mem[32'h10] = 32'h0000_0513;
    mem[32'h20] = 32'h00A0_0093;

    //        kind  addr    wdata         be    wt hang exp_rd        chk err cyc
    vt[0]  = '{K_I,  32'h10,  32'h0,        4'h0, 0, 1'b0, 32'h0000_0513, 1'b1, 1'b0, 1};
    vt[1]  = '{K_ST, 32'h100, 32'hDEAD_BEEF, 4'h3, 0, 1'b0, 32'h0,         1'b0, 1'b0, 1};
    vt[2]  = '{K_LD, 32'h100, 32'h0,        4'h0, 0, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0, 1};
    vt[3]  = '{K_LD, 32'h100, 32'h0,        4'h0, 5, 1'b0, 32'h0000_BEEF, 1'b1, 1'b0, 6};
    vt[4]  = '{K_I,  32'h20,  32'h0,        4'h0, 3, 1'b0, 32'h00A0_0093, 1'b1, 1'b0, 4};
    vt[5]  = '{K_LD, 32'h200, 32'h0,        4'h0, 0, 1'b1, 32'h0,         1'b1, 1'b1, TMO};
    vt[6]  = '{K_I,  32'h10,  32'h0,        4'h0, 0, 1'b0, 32'h0000_0513, 1'b1, 1'b0, 1};
    vt[7]  = '{K_ST, 32'h104, 32'h1234_5678, 4'hC, 2, 1'b0, 32'h0,         1'b0, 1'b0, 3};
    vt[8]  = '{K_I,  32'h104, 32'h0,        4'h0, 1, 1'b0, 32'h1234_0000, 1'b1, 1'b0, 2};
    vt[9]  = '{K_I,  32'h300, 32'h0,        4'h0, 0, 1'b1, 32'h0,         1'b1, 1'b1, TMO};
    vt[10] = '{K_ST, 32'h100, 32'hCAFE_F00D, 4'hF, 0, 1'b0, 32'h0,         1'b0, 1'b0, 1};
    vt[11] = '{K_LD, 32'h100, 32'h0,        4'h0, 2, 1'b0, 32'hCAFE_F00D, 1'b1, 1'b0, 3};

    // reset state
    tick(); tick();
    check("rst_if_valid",  32'(bus.if_valid), 32'd0);
    check("rst_d_valid",   32'(bus.d_valid),  32'd0);
    check("rst_err",       32'(bus.err),      32'd0);
    check("rst_mem_req",   32'(bus.mem_req),  32'd0);
    check("rst_mem_we",    32'(bus.mem_we),   32'd0);
    check("rst_mem_addr",  bus.mem_addr,      32'd0);
    check("rst_mem_wdata", bus.mem_wdata,     32'd0);
    check("rst_mem_be",    32'(bus.mem_be),   32'd0);
    check("rst_if_rdata",  bus.if_rdata,      32'd0);
    check("rst_d_rdata",   bus.d_rdata,       32'd0);
    rst = 1'b1;

    // vector table
    for (int i = 0; i < 12; i++) begin
      wait_cfg = vt[i].wt; hang = vt[i].hng;
      xact(vt[i].k, vt[i].addr, vt[i].wd, vt[i].be, rd, e, lat, ok);
      hang = 1'b0;
      check($sformatf("vec%0d_valid", i), 32'(ok), 32'd1);
      if (vt[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(e), 32'(vt[i].exp_err));
      check($sformatf("vec%0d_req_cycles", i), 32'(last_req_cyc), 32'(vt[i].exp_cyc));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].exp_cyc + 1));
      check($sformatf("vec%0d_addr_stable", i), 32'(addr_moved), 32'd0);
      check($sformatf("vec%0d_grant_logged", i), 32'(gq.size() == 1), 32'd1);
      if (gq.size() != 0) begin
        g = gq.pop_front();
        check($sformatf("vec%0d_mem_addr", i), g.addr, vt[i].addr);
        check($sformatf("vec%0d_mem_we", i), 32'(g.we), 32'(vt[i].k == K_ST));
        check($sformatf("vec%0d_mem_be", i), 32'(g.be), 32'((vt[i].k == K_ST) ? vt[i].be : 4'hF));
      end
      gq.delete();
      tick();
      check($sformatf("vec%0d_pulse_width", i), 32'(bus.if_valid | bus.d_valid | bus.err), 32'd0);
    end

    // reset in the 3rd BUSY_D cycle of a load that never completes
    hang = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h100;
    cyc = 0;
    do begin tick(); cyc++; end while (bus.mem_req !== 1'b1 && cyc < 20);
    check("rstmid_started", 32'(bus.mem_req), 32'd1);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rstmid_mem_req",  32'(bus.mem_req),  32'd0);
    check("rstmid_d_valid",  32'(bus.d_valid),  32'd0);
    check("rstmid_err",      32'(bus.err),      32'd0);
    check("rstmid_d_rdata",  bus.d_rdata,       32'd0);
    check("rstmid_mem_addr", bus.mem_addr,      32'd0);
    check("rstmid_mem_be",   32'(bus.mem_be),   32'd0);
    repeat (3) begin
      tick();
      check("rstmid_no_valid", 32'(bus.d_valid | bus.if_valid | bus.mem_req), 32'd0);
    end
    bus.d_req = 1'b0; hang = 1'b0; wait_cfg = 0;
    rst = 1'b1;
    gq.delete();
    tick();
    xact(K_I, 32'h10, 32'h0, 4'h0, rd, e, lat, ok);
    check("rstmid_fetch_valid", 32'(ok), 32'd1);
    check("rstmid_fetch_rdata", rd, 32'h0000_0513);
    check("rstmid_fetch_err", 32'(e), 32'd0);
    tick();
    gq.delete();

    // both ports held busy: expect DDDDIDDDDI
    pat = "DDDDIDDDDI";
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h180; bus.d_wdata = 32'h5555_AAAA; bus.d_be = 4'hF;
    cyc = 0;
    while (gq.size() < 10 && cyc < 200) begin tick(); cyc++; end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    check("prio_grant_count", 32'(gq.size() >= 10), 32'd1);
    for (int i = 0; i < 10 && i < gq.size(); i++)
      check($sformatf("prio_grant%0d", i), 32'(gq[i].we ? 8'h44 : 8'h49), 32'(pat[i]));
    repeat (12) tick();
    gq.delete();

    // random traffic against the transaction-level model
    rst = 1'b0; tick(); rst = 1'b1;
    gq.delete();
    model_streak = 0;
    ref_mem = mem;
    rnd_wait = 1'b1;
    fork
      i_agent();
      d_agent();
    join
    rnd_wait = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
